// File: rtl/fxp_to_fp.sv
// fxp_to_fp: 3-stage streaming quantizer from wide signed fixed point to a sign/exp/man minifloat
// Rounds to nearest even and saturates on overflow; there is no Inf/NaN encoding.
module fxp_to_fp #(
    parameter int exp_width = 5,
    parameter int man_width = 2,
    parameter int bit_width = 1 + exp_width + man_width,
    parameter int bias = (1 << (exp_width - 1)) - 1,
    parameter int fxp_width = 2 * ((1 << exp_width) + man_width),
    parameter int fxp_frac = 2 * (bias - 1) + 2 * man_width
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_vld,
    output logic                 o_rdy,
    input  logic [fxp_width-1:0] i_fxp,
    output logic                 o_vld,
    input  logic                 i_rdy,
    output logic [bit_width-1:0] o_fp,
    output logic                 o_ovf,
    output logic                 o_unf
);
    localparam int pw = $clog2(fxp_width);
    localparam int ew = pw + 2;
    localparam int sub_lsb = fxp_frac + 1 - bias - man_width;
    localparam int max_e = (1 << exp_width) - 1;

    logic en;
    assign en = ~o_vld | i_rdy;
    assign o_rdy = en;

    logic [fxp_width-1:0] mag;
    logic [pw-1:0] lead;
    assign mag = i_fxp[fxp_width-1] ? -i_fxp : i_fxp;
    always_comb begin
        lead = '0;
        for (int i = 0; i < fxp_width; i++)
            if (mag[i]) lead = pw'(i);
    end

    logic s1_vld, s1_sign, s1_zero;
    logic [fxp_width-1:0] s1_mag;
    logic [pw-1:0] s1_p;

    logic signed [ew-1:0] e, e_base, e_rnd;
    logic normal, guard, sticky;
    logic [pw-1:0] lsb;
    logic [man_width+1:0] win, rnd;
    logic [fxp_width-1:0] low;
    assign e = ew'(s1_p) + ew'(bias - fxp_frac);
    assign normal = ~e[ew-1] & (e != '0);
    // Subnormals share one fixed LSB weight; normals keep man_width bits under the leading one
    assign lsb = normal ? s1_p - pw'(man_width) : pw'(sub_lsb);
    assign win = (man_width + 2)'({s1_mag, 1'b0} >> lsb);
    assign guard = win[0];
    assign low = ~({fxp_width{1'b1}} << lsb) >> 1;
    assign sticky = |(s1_mag & low);
    assign rnd = {1'b0, win[man_width+1:1]} + {{(man_width + 1){1'b0}}, guard & (sticky | win[1])};
    assign e_base = normal ? e : '0;
    // Carry past the hidden bit, or a subnormal reaching the hidden bit, bumps the exponent
    assign e_rnd = e_base + {{(ew - 1){1'b0}}, rnd[man_width+1] | (~normal & rnd[man_width])};

    logic s2_vld, s2_sign, s2_zero, s2_unf;
    logic signed [ew-1:0] s2_e;
    logic [man_width-1:0] s2_man;
    logic ovf;
    assign ovf = s2_e > ew'(max_e);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_vld <= 1'b0;
            s1_sign <= 1'b0;
            s1_zero <= 1'b0;
            s1_mag <= '0;
            s1_p <= '0;
            s2_vld <= 1'b0;
            s2_sign <= 1'b0;
            s2_zero <= 1'b0;
            s2_unf <= 1'b0;
            s2_e <= '0;
            s2_man <= '0;
            o_vld <= 1'b0;
            o_fp <= '0;
            o_ovf <= 1'b0;
            o_unf <= 1'b0;
        end else if (en) begin
            s1_vld <= i_vld;
            s1_sign <= i_fxp[fxp_width-1];
            s1_zero <= i_fxp == '0;
            s1_mag <= mag;
            s1_p <= lead;
            s2_vld <= s1_vld;
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_unf <= ~s1_zero & (rnd == '0);
            s2_e <= e_rnd;
            s2_man <= rnd[man_width-1:0];
            o_vld <= s2_vld;
            o_fp <= s2_zero ? '0 : ovf ? {s2_sign, {(bit_width - 1){1'b1}}} : {s2_sign, s2_e[exp_width-1:0], s2_man};
            o_ovf <= ~s2_zero & ovf;
            o_unf <= s2_unf;
        end
    end
endmodule

// File: tb/tb_fxp_to_fp.sv
// tb_fxp_to_fp: randomized and directed checks of fxp_to_fp against a nearest-code search model
module tb_fxp_to_fp;
    localparam int W = 68;
    localparam int sub_sh = 16;
    localparam int norm_sh = 15;
    localparam logic [W:0] top_lim = ((W + 1)'(7) << 46) + ((W + 1)'(1) << 45);

    logic clk = 1'b0;
    logic rst, vld_in, rdy_out, vld_out, rdy_in, ovf, unf;
    logic [W-1:0] fxp;
    logic [7:0] fp;
    int n_tests = 0;
    int n_fail = 0;

    fxp_to_fp dut (
        .i_clk(clk), .i_rst(rst), .i_vld(vld_in), .o_rdy(rdy_out), .i_fxp(fxp),
        .o_vld(vld_out), .i_rdy(rdy_in), .o_fp(fp), .o_ovf(ovf), .o_unf(unf)
    );

    initial forever #5 clk = ~clk;

    // Picks the closest of all 128 codes (ties to the even code); beyond the top tie it saturates
    function automatic logic [9:0] model(input logic [W-1:0] x);
        logic s;
        logic [W:0] mag, v, d, bd;
        logic [6:0] best;
        s = x[W-1];
        mag = s ? ((W + 1)'(1) << W) - {1'b0, x} : {1'b0, x};
        if (mag == '0) return '0;
        if (mag >= top_lim) return {s, 7'h7F, 2'b10};
        best = '0;
        bd = '1;
        for (int c = 0; c < 128; c++) begin
            v = (c >> 2) == 0 ? (W + 1)'(c & 3) << sub_sh : (W + 1)'(4 + (c & 3)) << ((c >> 2) + norm_sh);
            d = v > mag ? v - mag : mag - v;
            if (d < bd || (d == bd && c % 2 == 0)) begin
                best = 7'(c);
                bd = d;
            end
        end
        return {s, best, 1'b0, best == 7'd0};
    endfunction

    function automatic logic [W-1:0] rnd_word();
        logic [95:0] r;
        logic [W-1:0] x;
        r = {$urandom, $urandom, $urandom};
        x = r[W-1:0] >> $urandom_range(28, W - 1);
        if ($urandom_range(0, 15) == 0) x = '0;
        if ($urandom_range(0, 1) == 1) x = -x;
        return x;
    endfunction

    task automatic run_one(input logic [W-1:0] x, output logic [9:0] res, output int lat);
        @(negedge clk);
        vld_in = 1'b1;
        fxp = x;
        @(posedge clk);
        #1 vld_in = 1'b0;
        lat = 0;
        while (!vld_out && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        res = {fp, ovf, unf};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vld_in = 1'b0;
        rdy_in = 1'b1;
        fxp = '0;
        #12;
        n_tests++;
        if ({vld_out, fp, ovf, unf} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 000", {vld_out, fp, ovf, unf});
        end
        n_tests++;
        if (rdy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rdy: got %b expected 1", rdy_out);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({rdy_out, vld_out} !== 2'b10) begin
            n_fail++;
            $display("FAIL post_reset_rdy_vld: got %b expected 10", {rdy_out, vld_out});
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] xs[16];
        logic [9:0] ex[16];
        logic [9:0] res;
        int lat;
        xs[0] = 68'h1_0000_0000;              ex[0] = {8'h3C, 2'b00};
        xs[1] = '0 - (68'd3 << 31);           ex[1] = {8'hBE, 2'b00};
        xs[2] = 68'h1_2000_0000;              ex[2] = {8'h3C, 2'b00};
        xs[3] = 68'h1_6000_0000;              ex[3] = {8'h3E, 2'b00};
        xs[4] = 68'h1_2000_0001;              ex[4] = {8'h3D, 2'b00};
        xs[5] = 68'd1 << 16;                  ex[5] = {8'h01, 2'b00};
        xs[6] = 68'd3 << 14;                  ex[6] = {8'h01, 2'b00};
        xs[7] = 68'd1 << 15;                  ex[7] = {8'h00, 2'b01};
        xs[8] = '0 - (68'd1 << 15);           ex[8] = {8'h80, 2'b01};
        xs[9] = '0;                           ex[9] = {8'h00, 2'b00};
        xs[10] = 68'h1C000 << 32;             ex[10] = {8'h7F, 2'b00};
        xs[11] = 68'd1 << 60;                 ex[11] = {8'h7F, 2'b10};
        xs[12] = 68'd1 << 67;                 ex[12] = {8'hFF, 2'b10};
        xs[13] = 68'h1E000 << 32;             ex[13] = {8'h7F, 2'b10};
        xs[14] = 68'd7 << 15;                 ex[14] = {8'h04, 2'b00};
        xs[15] = '0 - (68'h1DFFF << 32);      ex[15] = {8'hFF, 2'b00};
        rdy_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            run_one(xs[i], res, lat);
            n_tests++;
            if (res !== ex[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: got fp/ovf/unf %h expected %h", i, res, ex[i]);
            end
            n_tests++;
            if (lat != 3) begin
                n_fail++;
                $display("FAIL latency_%0d: got %0d expected 3", i, lat);
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] q[$];
        logic [9:0] exp_v;
        logic acc = 1'b0;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        rdy_in = 1'b1;
        vld_in = 1'b0;
        while (got < 200 && cyc < 2000) begin
            @(posedge clk);
            #1;
            if (!vld_in || acc) begin
                vld_in = sent < 200 && $urandom_range(0, 3) != 0;
                fxp = rnd_word();
            end
            @(negedge clk);
            cyc++;
            if (vld_out && rdy_in) begin
                got++;
                n_tests++;
                exp_v = q.size() > 0 ? q.pop_front() : 10'h3FF;
                if ({fp, ovf, unf} !== exp_v) begin
                    n_fail++;
                    $display("FAIL random_%0d: got %h expected %h", got, {fp, ovf, unf}, exp_v);
                end
            end
            acc = vld_in && rdy_out;
            if (acc) begin
                q.push_back(model(fxp));
                sent++;
            end
        end
        vld_in = 1'b0;
        n_tests++;
        if (got != 200 || q.size() != 0) begin
            n_fail++;
            $display("FAIL random_count: got %0d outputs (%0d queued) expected 200", got, q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] q[$];
        logic [9:0] exp_v, held;
        logic pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic acc = 1'b0;
        logic stall = 1'b0;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        held = '0;
        while (got < 6 && cyc < 200) begin
            @(posedge clk);
            #1;
            rdy_in = pat[cyc % 6];
            if (!vld_in || acc) begin
                vld_in = sent < 6;
                fxp = rnd_word();
            end
            @(negedge clk);
            cyc++;
            n_tests++;
            if (rdy_out !== (!vld_out || rdy_in)) begin
                n_fail++;
                $display("FAIL rdy_rule_%0d: got %b expected %b", cyc, rdy_out, !vld_out || rdy_in);
            end
            if (stall) begin
                n_tests++;
                if (!vld_out || {fp, ovf, unf} !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold_%0d: got vld %b %h expected vld 1 %h", cyc, vld_out, {fp, ovf, unf}, held);
                end
            end
            stall = vld_out && !rdy_in;
            held = {fp, ovf, unf};
            if (vld_out && rdy_in) begin
                got++;
                n_tests++;
                exp_v = q.size() > 0 ? q.pop_front() : 10'h3FF;
                if ({fp, ovf, unf} !== exp_v) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got %h expected %h", got, {fp, ovf, unf}, exp_v);
                end
            end
            acc = vld_in && rdy_out;
            if (acc) begin
                q.push_back(model(fxp));
                sent++;
            end
        end
        vld_in = 1'b0;
        rdy_in = 1'b1;
        n_tests++;
        if (got != 6 || q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs (%0d queued) expected 6", got, q.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midflight();
        logic [9:0] res;
        logic stale = 1'b0;
        int lat;
        rdy_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vld_in = 1'b1;
            fxp = rnd_word();
        end
        @(posedge clk);
        #1 vld_in = 1'b0;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({vld_out, fp, ovf, unf, rdy_out} !== 12'd1) begin
            n_fail++;
            $display("FAIL midflight_reset: got vld/fp/ovf/unf/rdy %h expected 001", {vld_out, fp, ovf, unf, rdy_out});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (vld_out) stale = 1'b1;
        end
        n_tests++;
        if (stale) begin
            n_fail++;
            $display("FAIL stale_output: got o_vld 1 expected 0");
        end
        run_one(68'h1_0000_0000, res, lat);
        n_tests++;
        if (res !== {8'h3C, 2'b00} || lat != 3) begin
            n_fail++;
            $display("FAIL after_reset: got %h lat %0d expected 0f0 lat 3", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
